// File: rtl/row_fetch_ctrl_pkg.sv
// Shared types and constants for the row fetch controller.
// A row is PADL + SIZE pixels + PADR, each pixel lasting CHANNEL cycles.
package row_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_PADL = 3'd2,
        ST_DATA = 3'd3,
        ST_PADR = 3'd4
    } fsm_t;

    localparam int DEF_SIZE    = 56;
    localparam int DEF_CHANNEL = 64;
    localparam int DEF_PADWAIT = 21;
    localparam int ROW_CYC     = (DEF_SIZE + 2) * DEF_CHANNEL;

    function automatic int row_cyc(input int size, input int channel);
        return (size + 2) * channel;
    endfunction

endpackage

// File: rtl/row_fetch_ctrl_cycle_cnt.sv
// Up-counter with synchronous clear and terminal-count flag; wraps to zero
// on the enabled terminal cycle so the next phase always starts from zero.
module row_fetch_ctrl_cycle_cnt #(
    parameter int W = 8
) (
    input  logic         i_sclk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    assign o_tc = i_en && (r_cnt == i_last);

    always_ff @(posedge i_sclk) begin
        if (!i_rst_n || i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/row_fetch_ctrl.sv
// Row fetch controller: turns per-row triggers into zero-padded row timing and
// FIFO read requests, adding automatic top/bottom pad rows around each frame.
module row_fetch_ctrl
    import row_fetch_ctrl_pkg::*;
#(
    parameter int SIZE    = DEF_SIZE,
    parameter int CHANNEL = DEF_CHANNEL,
    parameter int PADWAIT = DEF_PADWAIT
) (
    input  logic       i_sclk,
    input  logic       i_rst_n,
    input  logic       i_vsync,
    input  logic       i_hsync,
    input  logic       i_fifo_empty,
    output logic       o_rdreq,
    output logic       o_vsync,
    output logic       o_hsync,
    output logic       o_reuse,
    output logic       o_valid,
    output logic [7:0] o_row,
    output logic       o_done,
    output logic       o_err
);

    localparam int DATA_CYC = SIZE * CHANNEL;
    localparam int CW       = (DATA_CYC > 1) ? $clog2(DATA_CYC) : 1;
    localparam logic [7:0] LAST_ROW  = 8'(SIZE + 1);
    localparam logic [7:0] BOT_DATA  = 8'(SIZE);
    localparam logic [7:0] REUSE_MAX = 8'(SIZE - 2);

    if ((SIZE < 2) || (SIZE + 1 > 255) || (CHANNEL < 1) ||
        (PADWAIT < 1) || (PADWAIT > DATA_CYC)) begin : g_param_chk
        $error("row_fetch_ctrl: unsupported SIZE/CHANNEL/PADWAIT");
    end

    fsm_t          r_state, w_state_nxt;
    logic [7:0]    r_row, w_row_nxt;
    logic          r_pend, w_pend_nxt;
    logic          r_err, w_err_nxt;
    logic          r_done, w_done_nxt;
    logic          r_vsync, r_valid, r_hsync, r_reuse;
    logic          w_pad_row, w_rd, w_en, w_tc, w_hs_nxt;
    logic [CW-1:0] w_last;

    assign w_pad_row = (r_row == 8'd0) || (r_row == LAST_ROW);
    // Read only while the FIFO has data; pad rows never touch the FIFO.
    assign w_rd      = (r_state == ST_DATA) && !w_pad_row && !i_fifo_empty;

    always_comb begin
        w_en   = 1'b1;
        w_last = CW'(CHANNEL - 1);
        case (r_state)
            ST_IDLE: begin
                w_en   = 1'b0;
                w_last = '0;
            end
            ST_WAIT: w_last = CW'(PADWAIT - 1);
            ST_DATA: begin
                w_last = CW'(DATA_CYC - 1);
                w_en   = w_pad_row || !i_fifo_empty;
            end
            default: ;
        endcase
    end

    row_fetch_ctrl_cycle_cnt #(.W(CW)) u_cnt (
        .i_sclk  (i_sclk),
        .i_rst_n (i_rst_n),
        .i_load  (i_vsync),
        .i_en    (w_en),
        .i_last  (w_last),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_pend_nxt  = r_pend;
        w_err_nxt   = r_err;
        w_done_nxt  = 1'b0;
        if ((r_state != ST_IDLE) && i_hsync) begin
            if (r_pend) w_err_nxt  = 1'b1;
            else        w_pend_nxt = 1'b1;
        end
        case (r_state)
            ST_IDLE: if (i_hsync || r_pend) begin
                w_state_nxt = ST_WAIT;
                // A fresh trigger arriving while the pending one is consumed takes its slot.
                w_pend_nxt  = r_pend && i_hsync;
            end
            ST_WAIT: if (w_tc) w_state_nxt = ST_PADL;
            ST_PADL: if (w_tc) w_state_nxt = ST_DATA;
            ST_DATA: if (w_tc) w_state_nxt = ST_PADR;
            ST_PADR: if (w_tc) begin
                if (r_row == LAST_ROW) begin
                    w_row_nxt   = 8'd0;
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_row_nxt   = r_row + 8'd1;
                    w_state_nxt = ((r_row == 8'd0) || (r_row == BOT_DATA)) ? ST_WAIT : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (i_vsync) begin
            w_state_nxt = ST_IDLE;
            w_row_nxt   = 8'd0;
            w_pend_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    assign w_hs_nxt = (w_state_nxt == ST_PADL) || (w_state_nxt == ST_DATA) ||
                      (w_state_nxt == ST_PADR);

    always_ff @(posedge i_sclk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_row   <= 8'd0;
            r_pend  <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_vsync <= 1'b0;
            r_valid <= 1'b0;
            r_hsync <= 1'b0;
            r_reuse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_pend  <= w_pend_nxt;
            r_err   <= w_err_nxt;
            r_done  <= w_done_nxt;
            r_vsync <= i_vsync;
            r_valid <= w_rd;
            r_hsync <= w_hs_nxt;
            r_reuse <= w_hs_nxt && (w_row_nxt >= 8'd1) && (w_row_nxt <= REUSE_MAX);
        end
    end

    assign o_rdreq = w_rd;
    assign o_vsync = r_vsync;
    assign o_hsync = r_hsync;
    assign o_reuse = r_reuse;
    assign o_valid = r_valid;
    assign o_row   = r_row;
    assign o_done  = r_done;
    assign o_err   = r_err;

endmodule

// File: tb/tb_row_fetch_ctrl.sv
// Scenario bench for row_fetch_ctrl (SIZE=4, CHANNEL=2, PADWAIT=3): expected
// rows are queued as triggers are driven and matched against rows the monitor sees.
`timescale 1ns/1ps
module tb_row_fetch_ctrl;

    localparam int SIZE    = 4;
    localparam int CHANNEL = 2;
    localparam int PADWAIT = 3;
    localparam int ROWLEN  = (SIZE + 2) * CHANNEL;

    logic       i_sclk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_vsync = 1'b0;
    logic       i_hsync = 1'b0;
    logic       i_fifo_empty = 1'b0;
    logic       o_rdreq, o_vsync, o_hsync, o_reuse, o_valid, o_done, o_err;
    logic [7:0] o_row;

    typedef struct packed {
        logic [7:0]  row;
        logic [15:0] hs;
        logic [15:0] rd;
        logic [15:0] reuse;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    rec_t cur;
    logic in_row  = 1'b0;
    logic prev_rd = 1'b0;
    int   errors = 0, checks = 0;
    int   tot_rd = 0, done_cnt = 0, vmis = 0;

    always #5 i_sclk = ~i_sclk;

    row_fetch_ctrl #(.SIZE(SIZE), .CHANNEL(CHANNEL), .PADWAIT(PADWAIT)) dut (
        .i_sclk       (i_sclk),
        .i_rst_n      (i_rst_n),
        .i_vsync      (i_vsync),
        .i_hsync      (i_hsync),
        .i_fifo_empty (i_fifo_empty),
        .o_rdreq      (o_rdreq),
        .o_vsync      (o_vsync),
        .o_hsync      (o_hsync),
        .o_reuse      (o_reuse),
        .o_valid      (o_valid),
        .o_row        (o_row),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    // Monitor: one record per emitted row, plus global read/done/valid tallies.
    always @(negedge i_sclk) begin
        if (!i_rst_n) begin
            prev_rd = 1'b0;
        end else begin
            if (o_valid !== prev_rd) vmis++;
            prev_rd = o_rdreq;
        end
        if (o_rdreq === 1'b1) tot_rd++;
        if (o_done === 1'b1) done_cnt++;
        if (o_hsync === 1'b1) begin
            if (!in_row) begin
                in_row = 1'b1;
                cur = '{row: o_row, hs: 16'd0, rd: 16'd0, reuse: 16'd0};
            end
            cur.hs = cur.hs + 16'd1;
            if (o_rdreq === 1'b1) cur.rd = cur.rd + 16'd1;
            if (o_reuse === 1'b1) cur.reuse = cur.reuse + 16'd1;
        end else if (in_row) begin
            in_row = 1'b0;
            obs_q.push_back(cur);
        end
    end

    function automatic rec_t exp_row(input int r, input int stall);
        rec_t e;
        int   hs;
        hs      = ROWLEN + stall;
        e.row   = 8'(r);
        e.hs    = 16'(hs);
        e.rd    = (r >= 1 && r <= SIZE) ? 16'(SIZE * CHANNEL) : 16'd0;
        e.reuse = (r >= 1 && r <= SIZE - 2) ? 16'(hs) : 16'd0;
        return e;
    endfunction

    task automatic pulse_hsync();
        @(posedge i_sclk); #1 i_hsync = 1'b1;
        @(posedge i_sclk); #1 i_hsync = 1'b0;
    endtask

    task automatic wait_hs(input logic lvl, output int n);
        n = 0;
        @(negedge i_sclk);
        while (o_hsync !== lvl && n < 1000) begin
            n++;
            @(negedge i_sclk);
        end
        if (n >= 1000) n = -1;
    endtask

    task automatic wait_obs(input int k, output bit ok);
        int t;
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 2000) begin
            if (obs_q.size() >= k) ok = 1'b1;
            else begin
                t++;
                @(negedge i_sclk);
            end
        end
    endtask

    task automatic wait_reads(input int k, output int n);
        n = 0;
        for (int i = 0; i < 500 && n < k; i++) begin
            @(negedge i_sclk);
            if (o_rdreq === 1'b1) n++;
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_hsync = 1'b1; i_vsync = 1'b1;
        repeat (3) @(posedge i_sclk);
        #1;
        checks++;
        if ({o_rdreq, o_vsync, o_hsync, o_reuse, o_valid, o_done, o_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b need 0000000",
                     {o_rdreq, o_vsync, o_hsync, o_reuse, o_valid, o_done, o_err});
        end
        checks++;
        if (o_row !== 8'd0) begin errors++; $display("FAIL reset_row: got %0d need 0", o_row); end
        i_hsync = 1'b0; i_vsync = 1'b0;
        @(posedge i_sclk); #1 i_rst_n = 1'b1;
        repeat (10) @(negedge i_sclk);
        checks++;
        if (o_hsync !== 1'b0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_no_trigger: hsync=%b rows=%0d need 0/0", o_hsync, obs_q.size());
        end
    endtask

    task automatic test_single_row();
        int n; bit ok; rec_t e, o;
        pulse_hsync();
        exp_q.push_back(exp_row(0, 0));
        exp_q.push_back(exp_row(1, 0));
        wait_hs(1'b1, n);
        checks++;
        if (n !== PADWAIT) begin errors++; $display("FAIL single_latency: got %0d need %0d", n, PADWAIT); end
        wait_obs(2, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: rows %0d need 2", obs_q.size()); end
        while (ok && exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single_row: row/hs/rd/reuse got %0d/%0d/%0d/%0d need %0d/%0d/%0d/%0d",
                         o.row, o.hs, o.rd, o.reuse, e.row, e.hs, e.rd, e.reuse);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_stall();
        int n, bad; bit ok; rec_t e, o;
        pulse_hsync();
        exp_q.push_back(exp_row(2, 5));
        wait_reads(3, n);
        checks++;
        if (n != 3) begin errors++; $display("FAIL stall_reads_seen: got %0d need 3", n); end
        bad = 0;
        @(posedge i_sclk); #1 i_fifo_empty = 1'b1;
        repeat (5) begin
            @(negedge i_sclk);
            if (o_rdreq !== 1'b0 || o_hsync !== 1'b1) bad++;
        end
        @(posedge i_sclk); #1 i_fifo_empty = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_hold: bad cycles got %0d need 0", bad); end
        wait_obs(1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_timeout: rows %0d need 1", obs_q.size()); end
        while (ok && exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall_row: row/hs/rd/reuse got %0d/%0d/%0d/%0d need %0d/%0d/%0d/%0d",
                         o.row, o.hs, o.rd, o.reuse, e.row, e.hs, e.rd, e.reuse);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_pending();
        int n; bit ok; rec_t e, o;
        pulse_hsync();
        exp_q.push_back(exp_row(3, 0));
        wait_hs(1'b1, n);
        pulse_hsync();
        checks++;
        if (o_err !== 1'b0) begin errors++; $display("FAIL pend_first: err got %b need 0", o_err); end
        exp_q.push_back(exp_row(4, 0));
        exp_q.push_back(exp_row(5, 0));
        pulse_hsync();
        pulse_hsync();
        checks++;
        if (o_err !== 1'b1) begin errors++; $display("FAIL pend_err: err got %b need 1", o_err); end
        wait_hs(1'b0, n);
        wait_hs(1'b1, n);
        // one IDLE cycle already consumed, so only the WAIT cycles remain
        checks++;
        if (n !== PADWAIT) begin errors++; $display("FAIL pend_gap: got %0d need %0d", n, PADWAIT); end
        wait_obs(3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pend_timeout: rows %0d need 3", obs_q.size()); end
        while (ok && exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pend_row: row/hs/rd/reuse got %0d/%0d/%0d/%0d need %0d/%0d/%0d/%0d",
                         o.row, o.hs, o.rd, o.reuse, e.row, e.hs, e.rd, e.reuse);
            end
        end
        exp_q.delete(); obs_q.delete();
        repeat (3) @(negedge i_sclk);
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL frame_done: pulses got %0d need 1", done_cnt); end
        checks++;
        if (tot_rd != SIZE * SIZE * CHANNEL) begin
            errors++; $display("FAIL frame_reads: got %0d need %0d", tot_rd, SIZE * SIZE * CHANNEL);
        end
    endtask

    task automatic test_vsync();
        int n; bit ok; rec_t e, o;
        pulse_hsync();
        exp_q.push_back(exp_row(0, 0));
        exp_q.push_back(exp_row(1, 0));
        wait_obs(2, ok);
        pulse_hsync();
        exp_q.push_back(exp_row(2, 0));
        wait_obs(3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL vs_timeout: rows %0d need 3", obs_q.size()); end
        while (ok && exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL vs_row: row/hs/rd/reuse got %0d/%0d/%0d/%0d need %0d/%0d/%0d/%0d",
                         o.row, o.hs, o.rd, o.reuse, e.row, e.hs, e.rd, e.reuse);
            end
        end
        exp_q.delete(); obs_q.delete();
        pulse_hsync();
        wait_reads(3, n);
        checks++;
        if (o_err !== 1'b1) begin errors++; $display("FAIL vs_err_sticky: got %b need 1", o_err); end
        @(posedge i_sclk); #1 i_vsync = 1'b1; i_hsync = 1'b1;
        @(posedge i_sclk); #1 i_vsync = 1'b0; i_hsync = 1'b0;
        checks++;
        if ({o_rdreq, o_hsync, o_err, o_vsync} !== 4'b0001 || o_row !== 8'd0) begin
            errors++;
            $display("FAIL vs_abort: rdreq/hsync/err/vsync got %b row %0d need 0001 row 0",
                     {o_rdreq, o_hsync, o_err, o_vsync}, o_row);
        end
        @(posedge i_sclk); #1;
        checks++;
        if (o_vsync !== 1'b0 || o_hsync !== 1'b0) begin
            errors++; $display("FAIL vs_pulse: vsync/hsync got %b%b need 00", o_vsync, o_hsync);
        end
        wait_obs(1, ok);
        e = '{row: 8'd3, hs: 16'(CHANNEL + 4), rd: 16'd4, reuse: 16'd0};
        o = ok ? obs_q.pop_front() : '0;
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL vs_cut_row: row/hs/rd got %0d/%0d/%0d need %0d/%0d/%0d",
                     o.row, o.hs, o.rd, e.row, e.hs, e.rd);
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        int n, rd0; bit ok; rec_t e, o;
        pulse_hsync();
        wait_hs(1'b1, n);
        @(posedge i_sclk); #1 i_rst_n = 1'b0;
        @(posedge i_sclk); #1;
        checks++;
        if ({o_rdreq, o_vsync, o_hsync, o_reuse, o_valid, o_done, o_err} !== 7'b0 || o_row !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid_outs: got %b row %0d need 0000000 row 0",
                     {o_rdreq, o_vsync, o_hsync, o_reuse, o_valid, o_done, o_err}, o_row);
        end
        repeat (2) @(posedge i_sclk);
        #1 i_rst_n = 1'b1;
        wait_obs(1, ok);
        e = '{row: 8'd0, hs: 16'd2, rd: 16'd0, reuse: 16'd0};
        o = ok ? obs_q.pop_front() : '0;
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL rst_mid_cut: row/hs got %0d/%0d need 0/2", o.row, o.hs);
        end
        rd0 = tot_rd;
        repeat (40) @(negedge i_sclk);
        checks++;
        if (tot_rd != rd0 || obs_q.size() != 0 || o_hsync !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: reads %0d rows %0d need 0/0", tot_rd - rd0, obs_q.size());
        end
        pulse_hsync();
        exp_q.push_back(exp_row(0, 0));
        exp_q.push_back(exp_row(1, 0));
        wait_hs(1'b1, n);
        checks++;
        if (n !== PADWAIT) begin errors++; $display("FAIL rst_mid_latency: got %0d need %0d", n, PADWAIT); end
        wait_obs(2, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_mid_timeout: rows %0d need 2", obs_q.size()); end
        while (ok && exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rst_mid_row: row/hs/rd/reuse got %0d/%0d/%0d/%0d need %0d/%0d/%0d/%0d",
                         o.row, o.hs, o.rd, o.reuse, e.row, e.hs, e.rd, e.reuse);
            end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (vmis != 0) begin errors++; $display("FAIL valid_align: mismatched cycles got %0d need 0", vmis); end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_stall();
        test_pending();
        test_vsync();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
